// File: rtl/fft_peak_reader.sv
// Frame controller for the FFT core output side: start, wait, unload, then
// scan the xk stream for the largest |re|+|im| inside a bin window.
module fft_peak_reader #(
  parameter int N_LOG2  = 13,
  parameter int XK_W    = 38,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [N_LOG2-1:0] min_bin,
  input  logic [N_LOG2-1:0] max_bin,
  input  logic              fft_rfd,
  input  logic              fft_busy,
  input  logic              fft_edone,
  input  logic              fft_done,
  input  logic              fft_dv,
  input  logic [N_LOG2-1:0] fft_xk_index,
  input  logic [XK_W-1:0]   fft_xk_re,
  input  logic [XK_W-1:0]   fft_xk_im,
  output logic              fft_start,
  output logic              fft_unload,
  output logic [N_LOG2-1:0] peak_index,
  output logic [XK_W:0]     peak_mag,
  output logic              peak_valid,
  output logic              timeout_err,
  output logic              idle
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_SCAN   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  typedef struct packed {
    logic [XK_W-1:0]   re_abs;
    logic [XK_W-1:0]   im_abs;
    logic [N_LOG2-1:0] idx;
  } s1_t;

  logic [2:0]        state_q, state_d;
  logic [N_LOG2-1:0] win_lo_q, win_hi_q;
  logic [N_LOG2-1:0] beat_q;
  logic [TW-1:0]     timer_q;
  logic              drain_q;
  logic [2:1]        vld_pipe_q;
  s1_t               s1_q;
  logic [XK_W:0]     s2_mag_q;
  logic [N_LOG2-1:0] s2_idx_q;
  logic [XK_W:0]     best_mag_q, best_mag_d;
  logic [N_LOG2-1:0] best_idx_q, best_idx_d;
  logic [N_LOG2-1:0] peak_idx_q;
  logic [XK_W:0]     peak_mag_q;
  logic              peak_vld_q, start_q, unload_q, tmo_q;

  logic              beat, last_beat, in_win, tmo_hit, abort, cand;
  logic [XK_W-1:0]   re_abs, im_abs;
  logic              unused_status;

  // Core status lines are observed only; nothing waits on them.
  assign unused_status = fft_rfd ^ fft_busy ^ fft_edone;

  assign beat      = (state_q == S_SCAN) && fft_dv;
  assign last_beat = beat && (beat_q == '1);
  assign in_win    = (fft_xk_index >= win_lo_q) && (fft_xk_index <= win_hi_q);
  assign tmo_hit   = (timer_q == TMO_LAST);
  assign abort     = tmo_hit && (((state_q == S_WAIT) && !fft_done) ||
                                 ((state_q == S_SCAN) && !last_beat));

  // Two's-complement negate of the most negative value lands on 2^(XK_W-1) unsigned.
  assign re_abs = fft_xk_re[XK_W-1] ? -fft_xk_re : fft_xk_re;
  assign im_abs = fft_xk_im[XK_W-1] ? -fft_xk_im : fft_xk_im;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (fft_done) state_d = S_UNLOAD;
                else if (tmo_hit) state_d = S_IDLE;
      S_UNLOAD: state_d = S_SCAN;
      S_SCAN:   if (last_beat) state_d = S_DRAIN;
                else if (tmo_hit) state_d = S_IDLE;
      S_DRAIN:  if (drain_q) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strict greater-than keeps the first bin seen on ties.
  always_comb begin
    cand = vld_pipe_q[2] && ((state_q == S_SCAN) || (state_q == S_DRAIN)) &&
           (s2_mag_q > best_mag_q);
    best_mag_d = cand ? s2_mag_q : best_mag_q;
    best_idx_d = cand ? s2_idx_q : best_idx_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      win_lo_q   <= '0;
      win_hi_q   <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
      drain_q    <= 1'b0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_mag_q   <= '0;
      s2_idx_q   <= '0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      peak_idx_q <= '0;
      peak_mag_q <= '0;
      peak_vld_q <= 1'b0;
      start_q    <= 1'b0;
      unload_q   <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= (state_d == S_START);
      unload_q <= (state_d == S_UNLOAD);
      tmo_q    <= abort;
      timer_q  <= (state_d == state_q) ? timer_q + TW'(1) : '0;
      drain_q  <= (state_q == S_DRAIN) && !drain_q;

      if ((state_q == S_IDLE) && go) begin
        win_lo_q   <= min_bin;
        win_hi_q   <= max_bin;
        beat_q     <= '0;
        best_mag_q <= '0;
        best_idx_q <= min_bin;
      end else begin
        if (beat) beat_q <= beat_q + N_LOG2'(1);
        best_mag_q <= best_mag_d;
        best_idx_q <= best_idx_d;
      end

      // Window test is folded into the stage-1 valid so later stages only see candidates.
      vld_pipe_q <= {vld_pipe_q[1], beat && in_win};
      s1_q       <= '{re_abs: re_abs, im_abs: im_abs, idx: fft_xk_index};
      s2_mag_q   <= {1'b0, s1_q.re_abs} + {1'b0, s1_q.im_abs};
      s2_idx_q   <= s1_q.idx;

      peak_vld_q <= (state_d == S_REPORT);
      if (state_d == S_REPORT) begin
        peak_idx_q <= best_idx_d;
        peak_mag_q <= best_mag_d;
      end
    end
  end

  assign fft_start   = start_q;
  assign fft_unload  = unload_q;
  assign peak_index  = peak_idx_q;
  assign peak_mag    = peak_mag_q;
  assign peak_valid  = peak_vld_q;
  assign timeout_err = tmo_q;
  assign idle        = (state_q == S_IDLE);
endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed bench for fft_peak_reader: table of sparse frames plus timeout,
// gapped stream with stray go, and mid-scan reset sequences.
module tb_fft_peak_reader;
  localparam int N  = 13;
  localparam int W  = 38;
  localparam int NB = 1 << N;

  typedef struct packed {
    logic [N-1:0]        lo;
    logic [N-1:0]        hi;
    logic                brev;
    logic [2:0]          nb;
    logic [3:0][N-1:0]   bidx;
    logic [3:0][W-1:0]   bre;
    logic [3:0][W-1:0]   bim;
    logic [N-1:0]        eidx;
    logic [W:0]          emag;
  } vec_t;

  logic clk = 1'b0;
  logic reset, go, go_t, fft_done, done_t, fft_dv;
  logic [N-1:0] min_bin, max_bin, fft_xk_index;
  logic [W-1:0] fft_xk_re, fft_xk_im;
  logic fft_start, fft_unload, peak_valid, timeout_err, idle;
  logic [N-1:0] peak_index;
  logic [W:0]   peak_mag;
  logic t_start, t_unload, t_pv, t_tmo, t_idle;
  logic [N-1:0] t_pidx;
  logic [W:0]   t_pmag;

  int total = 0, bad = 0;
  int n_start = 0, n_valid = 0, n_tmo = 0;

  always #5 clk = ~clk;

  fft_peak_reader #(.N_LOG2(N), .XK_W(W), .TIMEOUT(65535)) dut (
    .clk(clk), .reset(reset), .go(go), .min_bin(min_bin), .max_bin(max_bin),
    .fft_rfd(1'b1), .fft_busy(1'b0), .fft_edone(1'b0), .fft_done(fft_done),
    .fft_dv(fft_dv), .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
    .fft_start(fft_start), .fft_unload(fft_unload), .peak_index(peak_index), .peak_mag(peak_mag),
    .peak_valid(peak_valid), .timeout_err(timeout_err), .idle(idle));

  fft_peak_reader #(.N_LOG2(N), .XK_W(W), .TIMEOUT(50)) dut_t (
    .clk(clk), .reset(reset), .go(go_t), .min_bin(min_bin), .max_bin(max_bin),
    .fft_rfd(1'b1), .fft_busy(1'b0), .fft_edone(1'b0), .fft_done(done_t),
    .fft_dv(fft_dv), .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
    .fft_start(t_start), .fft_unload(t_unload), .peak_index(t_pidx), .peak_mag(t_pmag),
    .peak_valid(t_pv), .timeout_err(t_tmo), .idle(t_idle));

  always @(negedge clk) begin
    if (fft_start)   n_start++;
    if (peak_valid)  n_valid++;
    if (timeout_err) n_tmo++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] lo, input logic [N-1:0] hi, input logic brev,
                              input logic [N-1:0] eidx, input logic [W:0] emag);
    vec_t v = '0;
    v.lo = lo; v.hi = hi; v.brev = brev; v.eidx = eidx; v.emag = emag;
    return v;
  endfunction

  function automatic vec_t add(input vec_t v, input logic [N-1:0] ix,
                               input logic [W-1:0] re, input logic [W-1:0] im);
    vec_t r = v;
    r.bidx[r.nb] = ix; r.bre[r.nb] = re; r.bim[r.nb] = im;
    r.nb = r.nb + 3'd1;
    return r;
  endfunction

  function automatic logic [N-1:0] brev13(input logic [N-1:0] b);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = b[N-1-i];
    return r;
  endfunction

  // One frame on the main DUT; rst_at >= 0 aborts with reset at that beat.
  task automatic run_frame(input vec_t v, input bit gaps, input int go_at, input int rst_at);
    int b;
    logic [N-1:0] ix;
    logic [W-1:0] re, im;
    chk("idle_before_go", idle, 1);
    min_bin = v.lo; max_bin = v.hi; go = 1;
    @(negedge clk); go = 0;
    chk("start_pulse", fft_start, 1);
    chk("idle_low_after_go", idle, 0);
    @(negedge clk);
    chk("start_one_cycle", fft_start, 0);
    fft_done = 1;
    @(negedge clk); fft_done = 0;
    chk("unload_pulse", fft_unload, 1);
    b = 0;
    while (b < NB) begin
      @(negedge clk);
      go = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        // Junk with a huge in-window magnitude while dv is low.
        fft_dv = 0; fft_xk_index = 13'd1234; fft_xk_re = 38'h1F_FFFF_FFFF; fft_xk_im = 38'h1F_FFFF_FFFF;
        continue;
      end
      if (b == rst_at) begin
        fft_dv = 0; reset = 1;
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_unload", fft_unload, 0);
        chk("rst_peak_mag", peak_mag, 0);
        @(negedge clk); reset = 0;
        return;
      end
      ix = v.brev ? brev13(b[N-1:0]) : b[N-1:0];
      re = '0; im = '0;
      for (int s = 0; s < 4; s++)
        if (s < int'(v.nb) && v.bidx[s] == ix) begin re = v.bre[s]; im = v.bim[s]; end
      fft_dv = 1; fft_xk_index = ix; fft_xk_re = re; fft_xk_im = im;
      if (b == go_at) go = 1;
      b++;
    end
    @(negedge clk); fft_dv = 0; go = 0;
    chk("drain1_no_valid", peak_valid, 0);
    @(negedge clk);
    chk("drain2_no_valid", peak_valid, 0);
    chk("drain2_busy", idle, 0);
    @(negedge clk);
    chk("report_valid", peak_valid, 1);
    chk("report_index", peak_index, v.eidx);
    chk("report_mag", peak_mag, v.emag);
    @(negedge clk);
    chk("valid_one_cycle", peak_valid, 0);
    chk("idle_after_report", idle, 1);
  endtask

  vec_t tbl[5];
  vec_t v;
  int s0, v0, t0;

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = add(mk(13'd0, 13'd8191, 1'b0, 13'd100, 39'd1000), 13'd100, 38'd1000, 38'd0);
    tbl[1] = add(mk(13'd0, 13'd8191, 1'b1, 13'd7, 39'h40_0000_0000), 13'd7,
                 38'h20_0000_0000, 38'h20_0000_0000);
    tbl[2] = add(mk(13'd0, 13'd8191, 1'b1, 13'd9, 39'd8), 13'd9, -38'sd5, 38'd3);
    v = mk(13'd10, 13'd3000, 1'b0, 13'd20, 39'd500);
    v = add(v, 13'd0, 38'd500, 38'd0);
    v = add(v, 13'd20, -38'sd300, -38'sd200);
    v = add(v, 13'd30, 38'd250, -38'sd250);
    tbl[3] = add(v, 13'd4000, 38'd900, 38'd0);
    tbl[4] = add(mk(13'd50, 13'd40, 1'b0, 13'd50, 39'd0), 13'd45, 38'd100, 38'd0);

    reset = 1; go = 0; go_t = 0; fft_done = 0; done_t = 0; fft_dv = 0;
    min_bin = '0; max_bin = '0; fft_xk_index = '0; fft_xk_re = '0; fft_xk_im = '0;
    #3;
    chk("reset_idle", idle, 1);
    chk("reset_start", fft_start, 0);
    chk("reset_unload", fft_unload, 0);
    chk("reset_valid", peak_valid, 0);
    chk("reset_index", peak_index, 0);
    chk("reset_mag", peak_mag, 0);
    chk("reset_tmo", timeout_err, 0);
    @(negedge clk); @(negedge clk); reset = 0;

    // fft_done never arrives on the TIMEOUT=50 instance.
    go_t = 1;
    @(negedge clk); go_t = 0;
    repeat (50) @(negedge clk);
    chk("tmo_not_yet", t_tmo, 0);
    chk("tmo_busy", t_idle, 0);
    @(negedge clk);
    chk("tmo_pulse", t_tmo, 1);
    chk("tmo_idle", t_idle, 1);
    chk("tmo_no_valid", t_pv, 0);
    chk("tmo_index_kept", t_pidx, 0);
    chk("tmo_mag_kept", t_pmag, 0);
    @(negedge clk);
    chk("tmo_one_cycle", t_tmo, 0);

    for (int i = 0; i < 5; i++) run_frame(tbl[i], 1'b0, -1, -1);

    // Gapped stream, stray go mid-scan.
    s0 = n_start; v0 = n_valid;
    v = add(mk(13'd0, 13'd8191, 1'b0, 13'd5000, 39'd579), 13'd5000, 38'd123, -38'sd456);
    v = add(v, 13'd6000, -38'sd578, 38'd0);
    run_frame(v, 1'b1, 1000, -1);
    repeat (3) @(negedge clk);
    chk("gap_start_count", n_start - s0, 1);
    chk("gap_report_count", n_valid - v0, 1);

    // Reset halfway through the scan, then a clean frame.
    v0 = n_valid; t0 = n_tmo;
    v = add(mk(13'd0, 13'd8191, 1'b0, 13'd3, 39'd9), 13'd3, 38'd7, -38'sd2);
    run_frame(add(v, 13'd100, 38'd5000, 38'd0), 1'b0, -1, 4096);
    repeat (6) @(negedge clk);
    chk("abort_no_report", n_valid - v0, 0);
    chk("abort_no_tmo", n_tmo - t0, 0);
    chk("abort_idle", idle, 1);
    run_frame(v, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
